tdm_demux_1x3: RTL and testbench

Time-division demultiplexer: the receive-side counterpart of the 3-to-1 channel multiplexers in the mux library. Accepts one serial stream of samples interleaved as slots 0, 1, 2 (slot 0 flagged by a frame-sync strobe), steers each sample to its channel, and presents the three channels together as one parallel frame. Sits between a TDM link receiver and the per-channel consumers, and tracks frame alignment.

---
 rtl/tdm_demux_1x3.sv | 114 +++++++++++
 tb/tb_tdm_demux_1x3.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux_1x3.sv
// Receive-side 1-to-3 TDM demultiplexer: steers interleaved slots 0/1/2 into a shadow frame,
// publishes complete frames on O and tracks frame alignment with a HUNT/RUN state machine.
module tdm_demux_1x3 #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   din,
   input  logic               din_valid,
   input  logic               frame_sync,
   output logic [3*WIDTH-1:0] O,
   output logic               frame_valid,
   output logic [1:0]         sel,
   output logic               locked,
   output logic               sync_err,
   output logic [CNT_W-1:0]   frame_cnt
);

   typedef enum logic [0:0] {StHunt, StRun} state_e;

   state_e             state_q, state_d;
   logic [1:0]         sel_q, sel_d;
   logic [WIDTH-1:0]   shadow0_q, shadow0_d;
   logic [WIDTH-1:0]   shadow1_q, shadow1_d;
   logic [3*WIDTH-1:0] o_q, o_d;
   logic               frame_valid_q, frame_valid_d;
   logic               sync_err_q, sync_err_d;
   logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StHunt;
         sel_q         <= 2'd0;
         shadow0_q     <= '0;
         shadow1_q     <= '0;
         o_q           <= '0;
         frame_valid_q <= 1'b0;
         sync_err_q    <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         sel_q         <= sel_d;
         shadow0_q     <= shadow0_d;
         shadow1_q     <= shadow1_d;
         o_q           <= o_d;
         frame_valid_q <= frame_valid_d;
         sync_err_q    <= sync_err_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      sel_d         = sel_q;
      shadow0_d     = shadow0_q;
      shadow1_d     = shadow1_q;
      o_d           = o_q;
      frame_valid_d = 1'b0;
      sync_err_d    = 1'b0;
      frame_cnt_d   = frame_cnt_q;

      if (din_valid) begin
         unique case (state_q)
            StHunt: begin
               // Unsynchronised samples are dropped silently while hunting.
               if (frame_sync) begin
                  shadow0_d = din;
                  sel_d     = 2'd1;
                  state_d   = StRun;
               end
            end
            StRun: begin
               if (frame_sync) begin
                  // A sync mid-frame restarts the frame without losing lock.
                  sync_err_d = (sel_q != 2'd0);
                  shadow0_d  = din;
                  sel_d      = 2'd1;
               end else begin
                  unique case (sel_q)
                     2'd1: begin
                        shadow1_d = din;
                        sel_d     = 2'd2;
                     end
                     2'd2: begin
                        o_d           = {din, shadow1_q, shadow0_q};
                        frame_valid_d = 1'b1;
                        frame_cnt_d   = frame_cnt_q + CNT_W'(1);
                        sel_d         = 2'd0;
                     end
                     default: begin
                        sync_err_d = 1'b1;
                        sel_d      = 2'd0;
                        state_d    = StHunt;
                     end
                  endcase
               end
            end
            default: begin
               state_d = StHunt;
               sel_d   = 2'd0;
            end
         endcase
      end
   end

   assign O           = o_q;
   assign frame_valid = frame_valid_q;
   assign sel         = sel_q;
   assign locked      = (state_q == StRun);
   assign sync_err    = sync_err_q;
   assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_tdm_demux_1x3.sv
// Self-checking bench for tdm_demux_1x3: directed scenarios plus random traffic compared
// against a queue-based frame-assembly model.
module tb_tdm_demux_1x3;

   localparam int unsigned W     = 1;
   localparam int unsigned CNT_W = 2;
   localparam int unsigned VW    = 3 * W + 1 + 2 + 1 + 1 + CNT_W;

   logic             clk;
   logic             rst_n;
   logic [W-1:0]     din;
   logic             din_valid;
   logic             frame_sync;
   logic [3*W-1:0]   O;
   logic             frame_valid;
   logic [1:0]       sel;
   logic             locked;
   logic             sync_err;
   logic [CNT_W-1:0] frame_cnt;

   tdm_demux_1x3 #(
      .WIDTH (W),
      .CNT_W (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (din),
      .din_valid   (din_valid),
      .frame_sync  (frame_sync),
      .O           (O),
      .frame_valid (frame_valid),
      .sel         (sel),
      .locked      (locked),
      .sync_err    (sync_err),
      .frame_cnt   (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   // Reference model: a frame is a queue of received slots; sel is simply its length.
   logic [W-1:0]     part[$];
   logic             m_locked;
   logic [3*W-1:0]   exp_O;
   logic             exp_fv;
   logic             exp_err;
   logic [1:0]       exp_sel;
   int               n_frames;
   logic [CNT_W-1:0] exp_cnt;

   logic [VW-1:0] dut_vec;
   logic [VW-1:0] exp_vec;
   assign dut_vec = {O, frame_valid, sel, locked, sync_err, frame_cnt};
   assign exp_vec = {exp_O, exp_fv, exp_sel, m_locked, exp_err, exp_cnt};

   task automatic model_reset();
      part     = {};
      m_locked = 1'b0;
      exp_O    = '0;
      exp_fv   = 1'b0;
      exp_err  = 1'b0;
      exp_sel  = 2'd0;
      n_frames = 0;
      exp_cnt  = '0;
   endtask

   task automatic model_edge(input logic v, input logic fs, input logic [W-1:0] d);
      exp_fv  = 1'b0;
      exp_err = 1'b0;
      if (v) begin
         if (!m_locked) begin
            if (fs) begin
               m_locked = 1'b1;
               part = {d};
            end
         end else if (fs) begin
            if (part.size() != 0) exp_err = 1'b1;
            part = {d};
         end else if (part.size() == 0) begin
            exp_err  = 1'b1;
            m_locked = 1'b0;
         end else begin
            part.push_back(d);
            if (part.size() == 3) begin
               exp_O    = {part[2], part[1], part[0]};
               exp_fv   = 1'b1;
               n_frames = n_frames + 1;
               exp_cnt  = CNT_W'(n_frames % (1 << CNT_W));
               part     = {};
            end
         end
      end
      exp_sel = 2'(part.size());
   endtask

   // Drives one cycle of input and advances the model; outputs are settled on return.
   task automatic drive(input logic v, input logic fs, input logic [W-1:0] d);
      @(negedge clk);
      din_valid  = v;
      frame_sync = fs;
      din        = d;
      @(posedge clk);
      model_edge(v, fs, d);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; din_valid = 1'b0; frame_sync = 1'b0; din = '0;
      model_reset();
      #1;
      total++;
      if (dut_vec !== '0) $display("FAIL reset_initial got=%h exp=0", dut_vec);
      else passed++;
      din_valid = 1'b1; frame_sync = 1'b1; din = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (dut_vec !== '0) $display("FAIL reset_held got=%h exp=0", dut_vec);
      else passed++;
      @(negedge clk);
      din_valid = 1'b0;
      rst_n = 1'b1;
      drive(1'b0, 1'b0, '0);
      total++;
      if (dut_vec !== exp_vec) $display("FAIL reset_release got=%h exp=%h", dut_vec, exp_vec);
      else passed++;
   endtask

   task automatic test_aligned();
      logic [W-1:0] vals[3];
      logic [1:0]   sels[3];
      vals = '{1'b1, 1'b0, 1'b1};
      sels = '{2'd1, 2'd2, 2'd0};
      total++;
      if (sel !== 2'd0) $display("FAIL aligned_sel_start got=%0d exp=0", sel);
      else passed++;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, i == 0, vals[i]);
         total++;
         if (sel !== sels[i]) $display("FAIL aligned_sel%0d got=%0d exp=%0d", i, sel, sels[i]);
         else passed++;
         total++;
         if (dut_vec !== exp_vec) $display("FAIL aligned_vec%0d got=%h exp=%h", i, dut_vec, exp_vec);
         else passed++;
      end
      total++;
      if ({O, frame_valid, frame_cnt} !== {3'b101, 1'b1, 2'd1})
         $display("FAIL aligned_frame got=%b/%b/%0d exp=101/1/1", O, frame_valid, frame_cnt);
      else passed++;
      drive(1'b0, 1'b0, '0);
      total++;
      if (frame_valid !== 1'b0) $display("FAIL aligned_pulse_width got=%b exp=0", frame_valid);
      else passed++;
   endtask

   task automatic test_pre_sync();
      logic [W-1:0] vals[3];
      vals = '{1'b0, 1'b1, 1'b1};
      // Drop lock first through a missing-sync error so the block is hunting.
      drive(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, W'($urandom));
         total++;
         if ({locked, sync_err} !== 2'b00)
            $display("FAIL presync_hunt%0d got=%b%b exp=00", i, locked, sync_err);
         else passed++;
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, i == 0, vals[i]);
         total++;
         if (dut_vec !== exp_vec) $display("FAIL presync_vec%0d got=%h exp=%h", i, dut_vec, exp_vec);
         else passed++;
      end
      total++;
      if (O !== 3'b110) $display("FAIL presync_O got=%b exp=110", O);
      else passed++;
   endtask

   task automatic test_early_sync();
      logic [CNT_W-1:0] cnt0;
      logic [3*W-1:0]   o0;
      cnt0 = exp_cnt;
      o0   = exp_O;
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b1);
      total++;
      if ({sync_err, locked, sel, O} !== {1'b1, 1'b1, 2'd1, o0})
         $display("FAIL early_err got=%b/%b/%0d/%b exp=1/1/1/%b", sync_err, locked, sel, O, o0);
      else passed++;
      drive(1'b1, 1'b0, 1'b0);
      total++;
      if (sync_err !== 1'b0) $display("FAIL early_err_width got=%b exp=0", sync_err);
      else passed++;
      drive(1'b1, 1'b0, 1'b0);
      total++;
      if ({O, frame_valid, frame_cnt} !== {3'b001, 1'b1, cnt0 + CNT_W'(1)})
         $display("FAIL early_frame got=%b/%b/%0d exp=001/1/%0d", O, frame_valid, frame_cnt,
                  cnt0 + CNT_W'(1));
      else passed++;
   endtask

   task automatic test_missing_sync();
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1);
      total++;
      if ({sync_err, locked, sel, O} !== {1'b1, 1'b0, 2'd0, 3'b011})
         $display("FAIL missing_err got=%b/%b/%0d/%b exp=1/0/0/011", sync_err, locked, sel, O);
      else passed++;
      drive(1'b1, 1'b1, 1'b0);
      total++;
      if ({sync_err, locked, sel} !== {1'b0, 1'b1, 2'd1})
         $display("FAIL missing_relock got=%b/%b/%0d exp=0/1/1", sync_err, locked, sel);
      else passed++;
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1);
      total++;
      if (dut_vec !== exp_vec) $display("FAIL missing_refr got=%h exp=%h", dut_vec, exp_vec);
      else passed++;
   endtask

   task automatic test_gaps_wrap();
      logic [CNT_W-1:0] seq[5];
      seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int f = 0; f < 5; f++) begin
         for (int k = 0; k < 3; k++) begin
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
               drive(1'b0, 1'($urandom), W'($urandom));
               total++;
               if (dut_vec !== exp_vec)
                  $display("FAIL gap_f%0d_s%0d got=%h exp=%h", f, k, dut_vec, exp_vec);
               else passed++;
            end
            drive(1'b1, k == 0, W'($urandom));
         end
         total++;
         if ({O, frame_valid, frame_cnt} !== {exp_O, 1'b1, seq[f]})
            $display("FAIL wrap_f%0d got=%b/%b/%0d exp=%b/1/%0d", f, O, frame_valid, frame_cnt,
                     exp_O, seq[f]);
         else passed++;
      end
   endtask

   task automatic test_random();
      logic fs;
      for (int i = 0; i < 400; i++) begin
         fs = (exp_sel == 2'd0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 14) == 0);
         drive($urandom_range(0, 3) != 0, fs, W'($urandom));
         total++;
         if (dut_vec !== exp_vec) $display("FAIL random_c%0d got=%h exp=%h", i, dut_vec, exp_vec);
         else passed++;
      end
   endtask

   task automatic test_async_reset();
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b1);
      total++;
      if ({O, sel, locked} !== {3'b111, 2'd2, 1'b1})
         $display("FAIL async_pre got=%b/%0d/%b exp=111/2/1", O, sel, locked);
      else passed++;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      total++;
      if (dut_vec !== '0) $display("FAIL async_immediate got=%h exp=0", dut_vec);
      else passed++;
      din_valid = 1'b1; frame_sync = 1'b0; din = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (dut_vec !== '0) $display("FAIL async_no_frame got=%h exp=0", dut_vec);
      else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 1'b1);
      total++;
      if ({locked, sel, sync_err, O} !== {1'b0, 2'd0, 1'b0, 3'b000})
         $display("FAIL async_hunt got=%b/%0d/%b/%b exp=0/0/0/000", locked, sel, sync_err, O);
      else passed++;
      drive(1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1);
      total++;
      if ({O, frame_cnt} !== {3'b100, 2'd1})
         $display("FAIL async_after got=%b/%0d exp=100/1", O, frame_cnt);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_aligned();
      test_pre_sync();
      test_early_sync();
      test_missing_sync();
      test_gaps_wrap();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
